// File: rtl/bp_bus_unpack_merge.sv
// bp_bus_unpack_merge: store-side lane unpacker and write-combining buffer.
// Sub-word stores arrive LSB-aligned with a unit offset and log2 size. Each
// accepted store is shifted into its lane and merged into a single staging
// word; the staged word is emitted toward the memory/L2 write port when it is
// fully covered, explicitly flushed, or displaced by a store to another word.
//
// Handshake: both ports use valid/ready. A transfer happens on a cycle where
// valid and ready are both high at the rising clock edge. valid never waits
// on ready. Once v_o is raised, addr_o/data_o/mask_o stay stable until the
// transfer. ready_and_o depends combinationally on addr_i (address match).
module bp_bus_unpack_merge #(
   parameter int width_p      = 64,
   parameter int unit_width_p = 8,
   parameter int addr_width_p = 40,
   localparam int units_lp      = width_p / unit_width_p,
   localparam int sel_width_lp  = (units_lp > 1) ? $clog2(units_lp) : 1,
   localparam int size_width_lp = $clog2(sel_width_lp + 1)
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     v_i,
   output logic                     ready_and_o,
   input  logic [addr_width_p-1:0]  addr_i,
   input  logic [sel_width_lp-1:0]  sel_i,
   input  logic [size_width_lp-1:0] size_i,
   input  logic [width_p-1:0]       data_i,
   input  logic                     flush_i,
   output logic                     v_o,
   input  logic                     ready_and_i,
   output logic [addr_width_p-1:0]  addr_o,
   output logic [width_p-1:0]       data_o,
   output logic [units_lp-1:0]      mask_o
);

   typedef enum logic [1:0] {
      EMPTY_S = 2'd0,
      FILL_S  = 2'd1,
      DRAIN_S = 2'd2
   } state_e;

   // state_q is the observable FSM state for checkers bound to this block
   state_e state_q, state_d;

   logic [addr_width_p-1:0]  addr_q, addr_d;
   logic [width_p-1:0]       data_q, data_d;
   logic [units_lp-1:0]      mask_q, mask_d;

   logic [size_width_lp-1:0] eff_size;
   logic [sel_width_lp-1:0]  eff_sel;
   int                       n_units;
   logic [units_lp-1:0]      lane_mask;
   logic [width_p-1:0]       lane_data;
   logic [units_lp-1:0]      merged_mask;
   logic [width_p-1:0]       merged_data;
   logic                     ready_int;
   logic                     accept;

   // Clamp size, naturally align the offset, and place the store in its lane
   always_comb begin
      eff_size = size_i;
      if (int'(size_i) > sel_width_lp) begin
         eff_size = size_width_lp'(sel_width_lp);
      end
      for (int b = 0; b < sel_width_lp; b++) begin
         eff_sel[b] = (b < int'(eff_size)) ? 1'b0 : sel_i[b];
      end
      n_units   = 1 << eff_size;
      lane_mask = '0;
      lane_data = '0;
      for (int k = 0; k < units_lp; k++) begin
         if ((k >= int'(eff_sel)) && (k < int'(eff_sel) + n_units)) begin
            lane_mask[k] = 1'b1;
            lane_data[k*unit_width_p +: unit_width_p] =
               data_i[(k - int'(eff_sel))*unit_width_p +: unit_width_p];
         end
      end
   end

   // Newer lane units override the staged ones; untouched units keep old data
   always_comb begin
      merged_mask = mask_q | lane_mask;
      merged_data = data_q;
      for (int k = 0; k < units_lp; k++) begin
         if (lane_mask[k]) begin
            merged_data[k*unit_width_p +: unit_width_p] =
               lane_data[k*unit_width_p +: unit_width_p];
         end
      end
   end

   // Request side accepts into an empty buffer or onto the same word
   always_comb begin
      ready_int = reset_n_i &
                  ((state_q == EMPTY_S) |
                   ((state_q == FILL_S) & (addr_i == addr_q)));
      accept    = v_i & ready_int;
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= EMPTY_S;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: drain on full coverage, flush, or a foreign address
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY_S: begin
            if (accept) begin
               state_d = ((&lane_mask) | flush_i) ? DRAIN_S : FILL_S;
            end
         end
         FILL_S: begin
            if (accept) begin
               state_d = ((&merged_mask) | flush_i) ? DRAIN_S : FILL_S;
            end else if (v_i | flush_i) begin
               state_d = DRAIN_S;
            end
         end
         DRAIN_S: begin
            if (ready_and_i) begin
               state_d = EMPTY_S;
            end
         end
         default: state_d = EMPTY_S;
      endcase
   end

   // FSM outputs; the mask is hidden while empty
   always_comb begin
      ready_and_o = ready_int;
      v_o         = (state_q == DRAIN_S);
      addr_o      = addr_q;
      data_o      = data_q;
      mask_o      = (state_q == EMPTY_S) ? '0 : mask_q;
   end

   // Staging word next value: load, merge, or clear after the drain transfer
   always_comb begin
      addr_d = addr_q;
      data_d = data_q;
      mask_d = mask_q;
      case (state_q)
         EMPTY_S: begin
            if (accept) begin
               addr_d = addr_i;
               data_d = lane_data;
               mask_d = lane_mask;
            end
         end
         FILL_S: begin
            if (accept) begin
               data_d = merged_data;
               mask_d = merged_mask;
            end
         end
         DRAIN_S: begin
            if (ready_and_i) begin
               data_d = '0;
               mask_d = '0;
            end
         end
         default: begin
            data_d = '0;
            mask_d = '0;
         end
      endcase
   end

   // Staging word registers
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         addr_q <= '0;
         data_q <= '0;
         mask_q <= '0;
      end else begin
         addr_q <= addr_d;
         data_q <= data_d;
         mask_q <= mask_d;
      end
   end

endmodule

// File: tb/tb_bp_bus_unpack_merge.sv
// Testbench for bp_bus_unpack_merge: lane placement table, hand-written
// merge/drain/reset sequences, and a randomized run against a byte-array model.
module tb_bp_bus_unpack_merge;

   localparam int W  = 64;
   localparam int AW = 40;

   logic          clk_i = 1'b0;
   logic          reset_n_i = 1'b0;
   logic          v_i;
   logic          ready_and_o;
   logic [AW-1:0] addr_i;
   logic [2:0]    sel_i;
   logic [1:0]    size_i;
   logic [W-1:0]  data_i;
   logic          flush_i;
   logic          v_o;
   logic          ready_and_i;
   logic [AW-1:0] addr_o;
   logic [W-1:0]  data_o;
   logic [7:0]    mask_o;

   bp_bus_unpack_merge #(
      .width_p(64), .unit_width_p(8), .addr_width_p(40)
   ) dut (
      .clk_i(clk_i), .reset_n_i(reset_n_i),
      .v_i(v_i), .ready_and_o(ready_and_o), .addr_i(addr_i),
      .sel_i(sel_i), .size_i(size_i), .data_i(data_i), .flush_i(flush_i),
      .v_o(v_o), .ready_and_i(ready_and_i), .addr_o(addr_o),
      .data_o(data_o), .mask_o(mask_o)
   );

   // clock
   always #5 clk_i = ~clk_i;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_store(input logic [AW-1:0] a, input logic [2:0] s,
                              input logic [1:0] z, input logic [W-1:0] d, input logic f);
      v_i = 1'b1; addr_i = a; sel_i = s; size_i = z; data_i = d; flush_i = f;
   endtask

   task automatic idle();
      v_i = 1'b0; flush_i = 1'b0;
   endtask

   // table of single stores placed from an empty buffer
   typedef struct {
      logic [2:0]  sel;
      logic [1:0]  size;
      logic [63:0] data;
      logic        flush;
      logic [63:0] exp_data;
      logic [7:0]  exp_mask;
   } vec_t;

   vec_t vecs[7];

   // behavioural model state for the random phase
   logic [111:0] exp_q[$];
   logic         m_open;
   logic [AW-1:0] m_addr;
   logic [7:0]   m_bytes[8];
   logic [7:0]   m_vmask;

   task automatic model_close();
      logic [63:0] wd;
      for (int u = 0; u < 8; u++) wd[8*u +: 8] = m_bytes[u];
      exp_q.push_back({m_addr, wd, m_vmask});
      m_open = 1'b0;
   endtask

   task automatic model_write(input logic [AW-1:0] a, input logic [2:0] s,
                              input logic [1:0] z, input logic [W-1:0] d);
      int eff, n, base;
      if (!m_open) begin
         m_open = 1'b1;
         m_addr = a;
         m_vmask = 8'h00;
         for (int u = 0; u < 8; u++) m_bytes[u] = 8'h00;
      end
      eff  = (int'(z) > 3) ? 3 : int'(z);
      n    = 1 << eff;
      base = int'(s) - (int'(s) % n);
      for (int i = 0; i < n; i++) begin
         m_bytes[base + i] = d[8*i +: 8];
         m_vmask[base + i] = 1'b1;
      end
   endtask

   initial begin
      logic [63:0] held_data;
      logic [111:0] front;
      logic exp_ready;

      vecs[0] = '{3'd3, 2'd0, 64'h0000_0000_0000_00AB, 1'b1, 64'h0000_0000_AB00_0000, 8'h08};
      vecs[1] = '{3'd3, 2'd1, 64'h0000_0000_0000_BEEF, 1'b1, 64'h0000_0000_BEEF_0000, 8'h0C};
      vecs[2] = '{3'd5, 2'd2, 64'h0000_0000_DEAD_BEEF, 1'b1, 64'hDEAD_BEEF_0000_0000, 8'hF0};
      vecs[3] = '{3'd7, 2'd3, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0123_4567_89AB_CDEF, 8'hFF};
      vecs[4] = '{3'd0, 2'd0, 64'hFFFF_FFFF_FFFF_FF5A, 1'b1, 64'h0000_0000_0000_005A, 8'h01};
      vecs[5] = '{3'd6, 2'd1, 64'h0000_0000_9876_5432, 1'b1, 64'h5432_0000_0000_0000, 8'hC0};
      vecs[6] = '{3'd1, 2'd2, 64'h1111_2222_3333_4444, 1'b1, 64'h0000_0000_3333_4444, 8'h0F};

      v_i = 1'b0; addr_i = '0; sel_i = '0; size_i = '0; data_i = '0;
      flush_i = 1'b0; ready_and_i = 1'b0;

      // reset state
      repeat (3) @(negedge clk_i);
      #1;
      check("rst_v_o", v_o, 0);
      check("rst_ready", ready_and_o, 0);
      check("rst_mask", mask_o, 0);
      check("rst_data", data_o, 0);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      #1;
      check("post_rst_ready", ready_and_o, 1);

      // table: single store from EMPTY, drained on flush or full coverage
      for (int i = 0; i < 7; i++) begin
         @(negedge clk_i);
         drive_store(40'h10, vecs[i].sel, vecs[i].size, vecs[i].data, vecs[i].flush);
         #1;
         check("tbl_ready", ready_and_o, 1);
         check("tbl_v_pre", v_o, 0);
         @(negedge clk_i);
         idle();
         #1;
         check("tbl_v_o", v_o, 1);
         check("tbl_data", data_o, vecs[i].exp_data);
         check("tbl_mask", mask_o, vecs[i].exp_mask);
         check("tbl_addr", addr_o, 40'h10);
         check("tbl_ready_drain", ready_and_o, 0);
         ready_and_i = 1'b1;
         @(negedge clk_i);
         ready_and_i = 1'b0;
         #1;
         check("tbl_v_empty", v_o, 0);
         check("tbl_mask_empty", mask_o, 0);
         check("tbl_ready_empty", ready_and_o, 1);
      end

      // FILL visibility: one byte staged, then flushed
      @(negedge clk_i);
      drive_store(40'h10, 3'd3, 2'd0, 64'hAB, 1'b0);
      @(negedge clk_i);
      idle();
      #1;
      check("fill_v_o", v_o, 0);
      check("fill_mask", mask_o, 8'h08);
      check("fill_data", data_o, 64'h0000_0000_AB00_0000);
      check("fill_ready", ready_and_o, 1);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      #1;
      check("fill_flush_v", v_o, 1);
      ready_and_i = 1'b1;
      @(negedge clk_i);
      ready_and_i = 1'b0;

      // EMPTY + flush is a no-op
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      #1;
      check("empty_flush_v", v_o, 0);
      check("empty_flush_ready", ready_and_o, 1);

      // eight byte stores complete the word
      for (int k = 0; k < 8; k++) begin
         @(negedge clk_i);
         drive_store(40'h10, 3'(k), 2'd0, 64'(8'h11 * (k + 1)), 1'b0);
         #1;
         check("fill8_ready", ready_and_o, 1);
         if (k == 7) begin
            check("fill8_v_pre", v_o, 0);
            check("fill8_mask_pre", mask_o, 8'h7F);
         end
      end
      @(negedge clk_i);
      idle();
      #1;
      check("fill8_v_o", v_o, 1);
      check("fill8_data", data_o, 64'h8877_6655_4433_2211);
      check("fill8_mask", mask_o, 8'hFF);
      ready_and_i = 1'b1;
      @(negedge clk_i);
      ready_and_i = 1'b0;

      // address conflict forces a drain; outputs hold while stalled
      drive_store(40'h10, 3'd0, 2'd0, 64'h5C, 1'b0);
      @(negedge clk_i);
      drive_store(40'h20, 3'd2, 2'd0, 64'h77, 1'b0);
      #1;
      check("conf_ready", ready_and_o, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         #1;
         check("conf_v_o", v_o, 1);
         check("conf_addr", addr_o, 40'h10);
         check("conf_data", data_o, 64'h5C);
         check("conf_mask", mask_o, 8'h01);
         check("conf_ready_drain", ready_and_o, 0);
      end
      ready_and_i = 1'b1;
      @(negedge clk_i);
      ready_and_i = 1'b0;
      #1;
      check("conf_v_empty", v_o, 0);
      check("conf_retry_ready", ready_and_o, 1);
      @(negedge clk_i);
      idle();
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      #1;
      check("conf_new_v", v_o, 1);
      check("conf_new_addr", addr_o, 40'h20);
      check("conf_new_data", data_o, 64'h0077_0000);
      check("conf_new_mask", mask_o, 8'h04);
      ready_and_i = 1'b1;
      @(negedge clk_i);
      ready_and_i = 1'b0;

      // overlapping stores: newer halfword overrides the older byte
      drive_store(40'h30, 3'd1, 2'd0, 64'hAA, 1'b0);
      @(negedge clk_i);
      drive_store(40'h30, 3'd0, 2'd1, 64'h1234, 1'b0);
      @(negedge clk_i);
      idle();
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      #1;
      check("ovl_v_o", v_o, 1);
      check("ovl_data", data_o, 64'h1234);
      check("ovl_mask", mask_o, 8'h03);
      held_data = data_o;
      // flush during DRAIN is ignored; word stays put
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      #1;
      check("drain_flush_v", v_o, 1);
      check("drain_flush_data", data_o, 64'h1234);

      // reset in the middle of a drain drops the word
      reset_n_i = 1'b0;
      #1;
      check("rst_drain_v", v_o, 0);
      check("rst_drain_ready", ready_and_o, 0);
      check("rst_drain_mask", mask_o, 0);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      #1;
      check("rst_rel_ready", ready_and_o, 1);
      check("rst_rel_v", v_o, 0);
      check("rst_rel_data", data_o, 0);

      // randomized run against the byte-array model
      exp_q.delete();
      m_open = 1'b0;
      m_addr = '0;
      m_vmask = 8'h00;
      for (int u = 0; u < 8; u++) m_bytes[u] = 8'h00;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk_i);
         v_i         = ($urandom_range(0, 9) < 7);
         addr_i      = ($urandom_range(0, 3) == 0) ? 40'h20 : 40'h10;
         sel_i       = 3'($urandom_range(0, 7));
         size_i      = 2'($urandom_range(0, 3));
         data_i      = {$urandom, $urandom};
         flush_i     = ($urandom_range(0, 9) == 0);
         ready_and_i = 1'($urandom_range(0, 1));
         #1;
         exp_ready = (exp_q.size() == 0) && (!m_open || (addr_i == m_addr));
         check("rnd_ready", ready_and_o, exp_ready);
         check("rnd_v_o", v_o, (exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            front = exp_q[0];
            check("rnd_drain_mask", mask_o, front[7:0]);
            if (ready_and_i) begin
               check("rnd_data", data_o, front[71:8]);
               check("rnd_addr", addr_o, front[111:72]);
               void'(exp_q.pop_front());
            end
         end else begin
            check("rnd_fill_mask", mask_o, m_open ? m_vmask : 8'h00);
            if (v_i && exp_ready) begin
               model_write(addr_i, sel_i, size_i, data_i);
               if ((m_vmask == 8'hFF) || flush_i) model_close();
            end else if (m_open && (v_i || flush_i)) begin
               model_close();
            end
         end
      end

      idle();
      ready_and_i = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
